uart_rx_cmd: RTL and testbench
==============================

UART_RX_CMD -- requirements
Module: uart_rx_cmd

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate.
REQ-003 Parameter OVS, default 16, oversampling ticks per bit.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 o_rx_data  output  8  received byte, valid only in the o_rx_done cycle, otherwise 8'h00.
REQ-008 o_rx_done  output  1  one-clock pulse, good frame received.
REQ-009 o_frame_err  output  1  one-clock pulse, stop bit sampled low.
REQ-010 The block SHALL use one clock (clk) and an asynchronous, active-low reset (reset_n).

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer before use; both flops hold 1 on reset; the FSM sees only the synchronized value rx_s.
REQ-012 A tick divider SHALL pulse one clk every DIV = CLK_HZ/(BAUD*OVS) clocks, rounded to nearest; the default is 651, giving a bit period of 10416 clk.
REQ-013 The divider SHALL free-run and restart from 0 on the IDLE->START transition, so sampling phase aligns to the start edge.
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP, BREAK.
REQ-015 IDLE: on rx_s==0, go to START and clear the tick counter; otherwise stay in IDLE.
REQ-016 START: at tick count OVS/2-1 (mid start bit), go to DATA if rx_s==0; go to IDLE if rx_s==1 (glitch rejection, no outputs).
REQ-017 DATA: every OVS ticks, sample rx_s into the shift register LSB-first; after the 8th sample, go to STOP.
REQ-018 STOP: after OVS ticks, sample rx_s.
REQ-019 STOP sample ==1: pulse o_rx_done and drive o_rx_data=byte in the same cycle, then go to IDLE.
REQ-020 STOP sample ==0: pulse o_frame_err and keep o_rx_data=8'h00, then go to BREAK.
REQ-021 BREAK: stay until rx_s==1, then go to IDLE; no start is detected while low.
REQ-022 o_rx_data SHALL be 8'h00 in every cycle except the o_rx_done cycle, so the downstream run/stop/clear FSM sees each command byte ('r' 8'h72, 's' 8'h73, 'c' 8'h63) for exactly one clk.
REQ-023 o_rx_done and o_frame_err SHALL never assert in the same cycle.
REQ-024 Outputs SHALL be registered.
REQ-025 Latency: o_rx_done rises about 9.5 bit periods after the start falling edge at the pin, plus 2-3 clk synchronizer and register delay.
REQ-026 Back-to-back frames with no idle gap beyond the stop bit SHALL be received without loss; a new start is detectable from the first IDLE cycle.
REQ-027 Shift register, bit counter (0-7, 3 bits) and tick counter (0 to OVS-1) SHALL be cleared on each IDLE->START transition.
REQ-028 No encoding other than a non-zero byte is implied; a received 8'h00 is still signalled by o_rx_done.

Reset
REQ-029 While reset_n==0: state=IDLE, all counters 0, shift register 0, synchronizer flops 1, o_rx_data=8'h00, o_rx_done=0, o_frame_err=0.
REQ-030 A reset asserted mid-frame SHALL abort the frame with no output pulse; after release, the block waits in IDLE for the next falling edge.
REQ-031 Reset release SHALL be handled without spurious start detection while rx is idle high.

Verification
REQ-032 Send 0x72 ('r') at 9600 baud -> exactly one o_rx_done pulse with o_rx_data=8'h72 in that cycle, 8'h00 before and after, o_frame_err=0.
REQ-033 Send 0x73 then 0x63 back-to-back, no gap -> two o_rx_done pulses, data 8'h73 then 8'h63, spaced 10 bit periods (104160 clk +/- 1 tick).
REQ-034 Low glitch of 3000 clk on idle rx -> no output pulse; state returns to IDLE; a following 0x72 is received correctly.
REQ-035 Frame 0x72 with stop bit forced low, rx held low 3 further bit periods -> one o_frame_err pulse, no o_rx_done, no further pulses until rx high; the next 0x63 is received.
REQ-036 reset_n pulsed low during data bit 4 of a frame -> no pulses for that frame, outputs 0; a subsequent 0x72 is received correctly.
REQ-037 Baud tolerance: send 0x55 at +2% and -2% bit rate -> o_rx_data=8'h55 with o_rx_done in both cases.

Source files
------------

// File: rtl/uart_rx_cmd_if.sv
// Serial line in, received command byte and status pulses out.
// master: receiver side (reads rx, drives results); slave: line driver / consumer.
interface uart_rx_cmd_if;
  logic       rx;
  logic [7:0] o_rx_data;
  logic       o_rx_done;
  logic       o_frame_err;

  modport master (
    input  rx,
    output o_rx_data,
    output o_rx_done,
    output o_frame_err
  );

  modport slave (
    output rx,
    input  o_rx_data,
    input  o_rx_done,
    input  o_frame_err
  );
endinterface

// File: rtl/uart_rx_cmd.sv
// 8N1 UART receiver with oversampled mid-bit sampling and frame-error/break handling.
// Ports: clk, reset_n (async active-low), bus (uart_rx_cmd_if.master: rx in; data/done/err out).
module uart_rx_cmd #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600,
  parameter int OVS    = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  uart_rx_cmd_if.master bus
);

  localparam int DIV_R = (CLK_HZ + (BAUD * OVS) / 2) / (BAUD * OVS);
  localparam int DIV   = (DIV_R < 1) ? 1 : DIV_R;
  localparam int DW    = $clog2(DIV + 1);
  localparam int TW    = $clog2(OVS + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [TW-1:0] T_MID    = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(OVS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic          r_rx_s1;
  logic          r_rx_s2;
  logic [DW-1:0] r_div;
  logic [TW-1:0] r_tick;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [2:0]    r_state;
  logic [7:0]    r_data;
  logic          r_done;
  logic          r_err;

  logic w_rx_s;
  logic w_tick;
  logic w_start;

  assign w_rx_s  = r_rx_s2;
  assign w_tick  = (r_div == DIV_LAST);
  assign w_start = (r_state == S_IDLE) && !w_rx_s;

  assign bus.o_rx_data   = r_data;
  assign bus.o_rx_done   = r_done;
  assign bus.o_frame_err = r_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= bus.rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  // Restarting on the start edge puts tick OVS/2 at mid start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= '0;
    end else if (w_start || w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_data <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_START;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (r_tick == T_MID) begin
              r_tick  <= '0;
              r_state <= w_rx_s ? S_IDLE : S_DATA;
            end else begin
              r_tick <= r_tick + TW'(1);
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_tick == T_LAST) begin
              r_tick  <= '0;
              r_shift <= {w_rx_s, r_shift[7:1]};
              r_bit   <= r_bit + 3'd1;
              if (r_bit == 3'd7) r_state <= S_STOP;
            end else begin
              r_tick <= r_tick + TW'(1);
            end
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (r_tick == T_LAST) begin
              r_tick <= '0;
              if (w_rx_s) begin
                r_done  <= 1'b1;
                r_data  <= r_shift;
                r_state <= S_IDLE;
              end else begin
                r_err   <= 1'b1;
                r_state <= S_BREAK;
              end
            end else begin
              r_tick <= r_tick + TW'(1);
            end
          end
        end
        S_BREAK: begin
          if (w_rx_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Randomized scoreboard bench for uart_rx_cmd.
// Stimulus queues expected bytes/errors; a monitor pops and compares on each output pulse.
module tb_uart_rx_cmd;

  localparam int CLK_HZ = 1_228_800;
  localparam int BAUD   = 9600;
  localparam int OVS    = 16;
  localparam int BT     = CLK_HZ / BAUD;
  localparam int LIMIT  = 95000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  uart_rx_cmd_if bus ();

  uart_rx_cmd #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .OVS    (OVS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    logic [7:0] data;
    bit         gap_chk;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   stim_done = 1'b0;

  task automatic push(input bit err, input logic [7:0] d, input bit g);
    exp_t e;
    e.err = err;
    e.data = d;
    e.gap_chk = g;
    exp_q.push_back(e);
  endtask

  task automatic drive_bit(input logic v, input int n);
    @(negedge clk);
    bus.rx = v;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    if (n > 0) drive_bit(1'b1, n * BT);
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input int bt);
    drive_bit(1'b0, bt);
    for (int i = 0; i < 8; i++) drive_bit(b[i], bt);
    drive_bit(stop, bt);
  endtask

  initial begin
    logic [7:0] b;
    int bt;
    int gap;
    bus.rx = 1'b1;
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    idle_bits(3);

    push(0, 8'h72, 0);
    send(8'h72, 1'b1, BT);
    idle_bits(2);

    drive_bit(1'b0, 37);
    drive_bit(1'b1, 2 * BT);
    push(0, 8'h72, 0);
    send(8'h72, 1'b1, BT);
    idle_bits(2);

    push(0, 8'h73, 0);
    push(0, 8'h63, 1);
    send(8'h73, 1'b1, BT);
    send(8'h63, 1'b1, BT);
    idle_bits(2);

    push(1, 8'h00, 0);
    send(8'h72, 1'b0, BT);
    drive_bit(1'b0, 3 * BT);
    drive_bit(1'b1, 2 * BT);
    push(0, 8'h63, 0);
    send(8'h63, 1'b1, BT);
    idle_bits(2);

    b = 8'h72;
    drive_bit(1'b0, BT);
    for (int i = 0; i < 4; i++) drive_bit(b[i], BT);
    drive_bit(b[4], BT / 2);
    @(negedge clk);
    reset_n = 1'b0;
    bus.rx = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    idle_bits(12);
    push(0, 8'h72, 0);
    send(8'h72, 1'b1, BT);
    idle_bits(2);

    push(0, 8'h00, 0);
    send(8'h00, 1'b1, BT);
    idle_bits(1);

    push(0, 8'h55, 0);
    send(8'h55, 1'b1, 131);
    idle_bits(2);
    push(0, 8'h55, 0);
    send(8'h55, 1'b1, 125);
    idle_bits(2);

    for (int k = 0; k < 24; k++) begin
      b = 8'($urandom);
      bt = $urandom_range(131, 125);
      gap = $urandom_range(3, 0);
      push(0, b, 0);
      send(b, 1'b1, bt);
      if (gap > 0 && $urandom_range(1, 0) == 1) begin
        drive_bit(1'b0, $urandom_range(40, 1));
        drive_bit(1'b1, gap * BT);
      end else begin
        idle_bits(gap);
      end
    end
    idle_bits(3);
    stim_done = 1'b1;
  end

  int cyc = 0;
  int last_done = 0;
  int bad_data = 0;
  int both = 0;

  initial begin
    exp_t e;
    int gap;
    while (!stim_done && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        checks++;
        if (bus.o_rx_done || bus.o_frame_err || bus.o_rx_data != 8'h00) begin
          failures++;
          $display("FAIL reset_out cyc=%0d done=%b err=%b data=%h want 0/0/00",
                   cyc, bus.o_rx_done, bus.o_frame_err, bus.o_rx_data);
        end
      end else begin
        if (bus.o_rx_done && bus.o_frame_err) both++;
        if (!bus.o_rx_done && bus.o_rx_data != 8'h00) bad_data++;
        if (bus.o_rx_done || bus.o_frame_err) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected cyc=%0d done=%b err=%b data=%h want none",
                     cyc, bus.o_rx_done, bus.o_frame_err, bus.o_rx_data);
          end else begin
            e = exp_q.pop_front();
            if (bus.o_frame_err != e.err || bus.o_rx_done == e.err ||
                (!e.err && bus.o_rx_data != e.data)) begin
              failures++;
              $display("FAIL frame cyc=%0d done=%b err=%b data=%h want err=%b data=%h",
                       cyc, bus.o_rx_done, bus.o_frame_err, bus.o_rx_data,
                       e.err, e.data);
            end
            if (e.gap_chk) begin
              checks++;
              gap = cyc - last_done;
              if (gap < 10 * BT - 8 || gap > 10 * BT + 8) begin
                failures++;
                $display("FAIL b2b_gap got=%0d want %0d+/-8", gap, 10 * BT);
              end
            end
          end
          if (bus.o_rx_done) last_done = cyc;
        end
      end
    end
    checks++;
    if (cyc >= LIMIT) begin
      failures++;
      $display("FAIL timeout cyc=%0d limit=%0d", cyc, LIMIT);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing got_left=%0d want 0", exp_q.size());
    end
    checks++;
    if (bad_data != 0) begin
      failures++;
      $display("FAIL data_not_zero cycles=%0d want 0", bad_data);
    end
    checks++;
    if (both != 0) begin
      failures++;
      $display("FAIL done_and_err cycles=%0d want 0", both);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
